// File: rtl/pt_mem_pkg.sv
// rtl/pt_mem_pkg.sv - shared frame geometry, write-buffer entry layout and pending-state type
package pt_mem_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIXEL_W  = 18;
  localparam int WORD_W   = 36;
  localparam int MADDR_W  = 18;

  typedef struct packed {
    logic [MADDR_W-1:0] addr;
    logic [1:0]         be;
    logic [WORD_W-1:0]  wdata;
  } pt_wr_entry_t;

  typedef enum logic {ST_IDLE, ST_HOLD} pend_state_t;

  // A half-word written on its own: the pixel sits in its lane, the other lane is disabled.
  function automatic pt_wr_entry_t single_entry(input logic [MADDR_W-1:0] addr,
                                                input logic               half,
                                                input logic [PIXEL_W-1:0] data);
    single_entry.addr  = addr;
    single_entry.be    = half ? 2'b10 : 2'b01;
    single_entry.wdata = half ? {data, {PIXEL_W{1'b0}}} : {{PIXEL_W{1'b0}}, data};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-based FIFO with occupancy count; push while full is legal with a pop
module sync_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pt_write_coalescer.sv
// rtl/pt_write_coalescer.sv - pairs even/odd pixels into 36-bit frame-buffer words and buffers them for the arbiter
module pt_write_coalescer #(
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_MAX   = 15,
  parameter int H_ACTIVE   = pt_mem_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = pt_mem_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] pt_pixel_write,
  input  logic [9:0]  pt_x,
  input  logic [8:0]  pt_y,
  input  logic        pt_wr,
  input  logic        frame_flag,
  output logic        ptflag,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [17:0] mem_addr,
  output logic [35:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        overflow,
  output logic [15:0] drop_count
);
  import pt_mem_pkg::*;

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          CW    = $clog2(HOLD_MAX + 1);
  localparam logic [9:0]  X_END = 10'(H_ACTIVE);
  localparam logic [8:0]  Y_END = 9'(V_ACTIVE);

  logic [18:0]        lin;
  logic [MADDR_W-1:0] new_addr;
  logic               new_half, in_range, pix_ok, space, accept, pop, push, load;
  logic               same_word, timeout, flush_q, flush_next;
  pend_state_t        state, state_next;
  logic [MADDR_W-1:0] pend_addr;
  logic               pend_half;
  logic [PIXEL_W-1:0] pend_data;
  logic [CW-1:0]      hold_cnt;
  pt_wr_entry_t       push_entry, head;
  logic               fifo_empty, fifo_full;
  logic [AW:0]        fifo_count, count_next;

  // y*640 as (y<<9)+(y<<7); bit 0 of the pixel index selects the half-word.
  assign lin      = {1'b0, pt_y, 9'd0} + {3'd0, pt_y, 7'd0} + {9'd0, pt_x};
  assign new_addr = lin[18:1];
  assign new_half = lin[0];
  assign in_range = (pt_x < X_END) && (pt_y < Y_END);

  assign mem_req    = !fifo_empty;
  assign pop        = mem_req && mem_grant;
  assign space      = !fifo_full || pop;
  assign pix_ok     = pt_wr && in_range;
  assign accept     = pix_ok && space;
  assign same_word  = (pend_addr == new_addr);
  assign timeout    = (hold_cnt >= CW'(HOLD_MAX));
  assign count_next = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_next = state;
    flush_next = flush_q;
    push       = 1'b0;
    load       = 1'b0;
    push_entry = '0;
    case (state)
      ST_IDLE: begin
        flush_next = 1'b0;
        if (accept) begin
          load       = 1'b1;
          state_next = ST_HOLD;
          flush_next = frame_flag;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (same_word && (new_half != pend_half)) begin
            push       = 1'b1;
            push_entry = '{addr: pend_addr, be: 2'b11,
                           wdata: pend_half ? {pend_data, pt_pixel_write}
                                            : {pt_pixel_write, pend_data}};
            state_next = ST_IDLE;
            flush_next = 1'b0;
          end else if (same_word) begin
            load       = 1'b1;
            flush_next = flush_q || frame_flag;
          end else begin
            push       = 1'b1;
            push_entry = single_entry(pend_addr, pend_half, pend_data);
            load       = 1'b1;
            flush_next = frame_flag;
          end
        end else if ((frame_flag || flush_q || timeout) && space) begin
          push       = 1'b1;
          push_entry = single_entry(pend_addr, pend_half, pend_data);
          state_next = ST_IDLE;
          flush_next = 1'b0;
        end else begin
          flush_next = flush_q || frame_flag;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      flush_q    <= 1'b0;
      pend_addr  <= '0;
      pend_half  <= 1'b0;
      pend_data  <= '0;
      hold_cnt   <= '0;
      ptflag     <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_next;
      flush_q <= flush_next;
      if (load) begin
        pend_addr <= new_addr;
        pend_half <= new_half;
        pend_data <= pt_pixel_write;
        hold_cnt  <= '0;
      end else if (state == ST_HOLD && !timeout) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      // Two free slots leave room for a strobe issued in the cycle ptflag drops.
      ptflag <= (count_next <= (AW+1)'(FIFO_DEPTH - 2));
      if (pix_ok && !space) overflow <= 1'b1;
      if (pt_wr && !in_range && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

  sync_fifo #(.WIDTH($bits(pt_wr_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_entry),
    .pop     (pop),
    .rdata   (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign mem_addr  = mem_req ? head.addr  : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;
  assign mem_be    = mem_req ? head.be    : '0;

endmodule

// File: tb/tb_pt_write_coalescer.sv
// tb/tb_pt_write_coalescer.sv - scoreboard bench for pt_write_coalescer
module tb_pt_write_coalescer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr, frame_flag, ptflag, mem_req, mem_grant, overflow;
  logic [17:0] mem_addr;
  logic [35:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [15:0] drop_count;

  typedef struct {
    logic [17:0] addr;
    logic        half;
    logic [17:0] data;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        mon_e;
  int          vectors = 0, miscompares = 0, writes = 0, drops_exp = 0;
  logic [1:0]  last_be;
  logic [17:0] last_addr;
  bit          stall_phase = 0, saw_low = 0, rand_grant = 0;
  int          last_word = -1;

  always #5 clk = ~clk;

  pt_write_coalescer dut (
    .clk(clk), .reset_n(reset_n), .pt_pixel_write(pt_pixel_write), .pt_x(pt_x), .pt_y(pt_y),
    .pt_wr(pt_wr), .frame_flag(frame_flag), .ptflag(ptflag), .mem_req(mem_req),
    .mem_grant(mem_grant), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .overflow(overflow), .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drives one pixel for one cycle; the expected pixel stream is the in-range pixels in issue order.
  task automatic issue(input int x, input int y, input logic [17:0] d, input bit ff, input bit keep);
    int n = 0;
    while (!ptflag && n < 400) begin
      saw_low = 1;
      if (stall_phase && !mem_grant && n == 30) begin
        check("stall_overflow", overflow, 0);
        check("stall_req_held", mem_req, 1);
        mem_grant = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("ptflag_timeout", ptflag, 1);
    pt_x = 10'(x); pt_y = 9'(y); pt_pixel_write = d; frame_flag = ff; pt_wr = 1;
    if (x < 640 && y < 480) begin
      if (keep) exp_q.push_back('{addr: 18'((y * 640 + x) / 2), half: 1'(x % 2), data: d});
    end else begin
      drops_exp++;
    end
    @(posedge clk); #1;
    pt_wr = 0; frame_flag = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mem_req) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic first_req_latency(input string name, input int required);
    int n = 1;
    while (!mem_req && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, required);
  endtask

  always @(negedge clk) begin
    if (reset_n && mem_req && mem_grant) begin
      writes++;
      last_be   = mem_be;
      last_addr = mem_addr;
      if (mem_be == 2'b00) check("write_be_nonzero", mem_be, 2'b01);
      for (int h = 0; h < 2; h++) begin
        if (mem_be[h]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr=%0d be=%b, required no write", mem_addr, mem_be);
          end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", mem_addr, mon_e.addr);
            check("write_half", h, mon_e.half);
            check("write_data", h ? mem_wdata[35:18] : mem_wdata[17:0], mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_grant) mem_grant = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int base;
    reset_n = 0; pt_pixel_write = '0; pt_x = '0; pt_y = '0;
    pt_wr = 0; frame_flag = 0; mem_grant = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ptflag", ptflag, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    check("ptflag_after_reset", ptflag, 1);
    mem_grant = 1;

    issue(0, 0, 18'h0A0A1, 0, 1);
    issue(1, 0, 18'h0B0B2, 0, 1);
    wait_drain("pair_drain");
    check("pair_be", last_be, 2'b11);
    check("pair_addr", last_addr, 0);

    issue(2, 1, 18'h0C0C3, 0, 1);
    first_req_latency("lone_latency", 17);
    wait_drain("lone_drain");
    check("lone_be", last_be, 2'b01);
    check("lone_addr", last_addr, 321);

    base = writes;
    issue(640, 0, 18'h11111, 0, 1);
    issue(0, 480, 18'h22222, 0, 1);
    repeat (30) @(posedge clk);
    #1;
    check("range_drop_count", drop_count, drops_exp);
    check("range_no_write", writes, base);

    issue(10, 0, 18'h0E0E0, 0, 0);
    issue(10, 0, 18'h0F0F0, 0, 1);
    issue(11, 0, 18'h01010, 0, 1);
    wait_drain("replace_drain");
    check("replace_be", last_be, 2'b11);
    check("replace_addr", last_addr, 5);

    issue(5, 0, 18'h0D0D0, 1, 1);
    first_req_latency("flush_latency", 2);
    wait_drain("flush_drain");
    check("flush_be", last_be, 2'b10);
    check("flush_addr", last_addr, 2);

    mem_grant = 0;
    stall_phase = 1;
    saw_low = 0;
    for (int i = 0; i < 20; i++) issue(20 + i, 3, 18'(32'h100 + i), 0, 1);
    stall_phase = 0;
    check("stall_ptflag_fell", saw_low, 1);
    mem_grant = 1;
    wait_drain("stall_drain");
    check("stall_overflow_end", overflow, 0);

    rand_grant = 1;
    for (int i = 0; i < 120; i++) begin
      int mode, y, xe;
      bit ff;
      mode = $urandom_range(0, 5);
      ff = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
      if (mode == 5) begin
        issue($urandom_range(640, 1023), $urandom_range(0, 511), 18'($urandom), ff, 1);
      end else if (mode == 4) begin
        issue($urandom_range(0, 639), $urandom_range(480, 511), 18'($urandom), ff, 1);
      end else begin
        do begin
          y  = $urandom_range(0, 479);
          xe = 2 * $urandom_range(0, 319);
        end while ((y * 640 + xe) / 2 == last_word);
        last_word = (y * 640 + xe) / 2;
        if (mode != 1) issue(xe, y, 18'($urandom), ff, 1);
        if (mode != 0) issue(xe + 1, y, 18'($urandom), 0, 1);
      end
    end
    rand_grant = 0;
    @(posedge clk); #1;
    mem_grant = 1;
    wait_drain("random_drain");
    check("random_drop_count", drop_count, drops_exp);
    check("random_overflow", overflow, 0);

    mem_grant = 0;
    for (int i = 0; i < 6; i++) issue(i, 7, 18'(32'h200 + i), 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_req_before", mem_req, 1);
    base = writes;
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_ptflag", ptflag, 0);
    check("midrst_mem_be", mem_be, 0);
    check("midrst_drop_count", drop_count, 0);
    exp_q.delete();
    mem_grant = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_stale_write", writes, base);
    check("midrst_ptflag_back", ptflag, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
